alarm_arbiter: RTL and testbench
================================

Name: alarm_arbiter

Overview:
Shares one alarm output bus (8-bit `out`, driving the buzzer/LED) between up to 8 independent alarm sources. Arbitration is round-robin, with a fixed time slice per source. A debounced acknowledge pulse, taken from the existing push-button cleaner, clears the currently sounding alarm. The block sits between the per-source alarm FSMs (request side) and the top-level output pins.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 32, time slice in clk cycles before rotating to another pending source; legal range 2..256.
- CNT_W, $clog2(HOLD_CYCLES), width of the slice counter (derived; never overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per source; high while that source is alerting.
- ack_pulse  in  1  single-cycle active-high acknowledge from the debouncer.
- grant  out  N_REQ  one-hot, registered; the source currently owning the output.
- ack_o  out  N_REQ  one-hot single-cycle pulse to the acknowledged source.
- out  out  8  alarm bus: [0]=active, [3:1]=granted index, [7:4]=0.
- busy  out  1  high in any state other than IDLE.
- slice_cnt  out  CNT_W  current slice count (debug/visibility).

Behaviour:
- Reset: async on reset=1.
  - state=IDLE, grant=0, ack_o=0, out=0, busy=0, slice_cnt=0, rr_ptr=0.
  - All outputs are registered.
- States: IDLE, ACTIVE, ACKED.
- Round-robin pick: first set bit of req scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
- IDLE:
  - If req!=0, the winner is registered. Next cycle: state=ACTIVE, grant=onehot(win), out={4'h0,win[2:0],1'b1}, slice_cnt=0.
  - Latency from req rising to grant is 1 cycle.
- ACTIVE (priority order, highest first):
  1. ack_pulse=1:
     - next state=ACKED, grant=0, out=0.
     - ack_o=onehot(cur) during the ACKED cycle.
     - rr_ptr=(cur+1) mod N_REQ.
  2. req[cur]=0 (source withdrew):
     - next state=IDLE, grant=0, out=0, no ack_o.
     - rr_ptr=(cur+1) mod N_REQ.
  3. slice_cnt==HOLD_CYCLES-1 and another req bit set:
     - rotate directly to the round-robin winner, scanning from cur+1.
     - grant/out update next cycle, slice_cnt=0, no dead cycle, no ack_o.
     - rr_ptr=(winner+1) mod N_REQ.
  4. slice_cnt==HOLD_CYCLES-1 and no other request: slice_cnt wraps to 0; grant is unchanged.
  5. Otherwise slice_cnt increments.
- ACKED:
  - Lasts exactly 1 cycle: ack_o pulses and out=0, then state=IDLE.
  - Re-arbitration happens from IDLE on the following edge, so minimum ack-to-next-grant is 2 cycles.
  - A source still holding req after ack_o is re-arbitrated normally; rr_ptr has already moved past it.
- ack_pulse in IDLE or ACKED is ignored; it is not latched.
- req bits may change on any cycle. Only req[cur] and the pick at decision points matter.
- busy = (state != IDLE).
- Reset asserted mid-slice: immediate return to reset values; no ack_o is emitted.

Decomposition:
- Shared package alarm_pkg holds:
  - state encoding constants IDLE=2'b00, ACTIVE=2'b01, ACKED=2'b10;
  - the out-bus field positions (ACTIVE_BIT=0, IDX_LSB=1, IDX_W=3).
- One sub-module: rr_pick.
  - Combinational, parameter N_REQ.
  - Inputs: req, start index.
  - Outputs: valid, index.
  - Used by both the IDLE pick and the slice-expiry rotation.

Test Plan:
- Reset then req=4'b0100 at cycle 0 -> grant=4'b0100, out=8'h05 at cycle 1; busy=1.
- Grant on ch2, single-cycle ack_pulse -> next cycle ack_o=4'b0100, out=0; cycle after, busy=0.
- req=4'b0011 held, HOLD_CYCLES=32 -> ch0 granted for 32 cycles, then ch1 (out=8'h03) with no gap, then back to ch0 after another 32.
- Only ch3 pending for 70 cycles -> grant stays 4'b1000; slice_cnt wraps 31->0 twice; no ack_o.
- ack_pulse and slice expiry in the same cycle with ch1 pending -> ack_o to current channel, ACKED, IDLE, then ch1 granted (ack wins).
- Async reset pulse mid-ACTIVE between clock edges -> outputs 0 immediately, no ack_o. After release, req=4'b1001 grants ch0 (rr_ptr=0).

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and alarm bus field layout
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ACKED  = 2'b10
    } state_t;

    localparam int ACTIVE_BIT = 0;
    localparam int IDX_LSB    = 1;
    localparam int IDX_W      = 3;

    // Alarm bus value while a source owns the output: active flag plus index
    function automatic logic [7:0] make_out(input logic [IDX_W-1:0] idx);
        make_out                    = '0;
        make_out[ACTIVE_BIT]        = 1'b1;
        make_out[IDX_LSB +: IDX_W]  = idx;
    endfunction

endpackage

// File: rtl/alarm_arbiter_rr_pick.sv
// rtl/alarm_arbiter_rr_pick.sv - round-robin first-set-bit search from a start index
module rr_pick
    import alarm_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan start, start+1, ... modulo N_REQ and keep the first hit
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid && |(req & (N_REQ'(1) << ((int'(start) + k) % N_REQ)))) begin
                valid = 1'b1;
                index = IDX_W'((int'(start) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/alarm_arbiter.sv
// rtl/alarm_arbiter.sv - round-robin time-sliced owner of the shared alarm output bus
module alarm_arbiter
    import alarm_pkg::*;
#(
    parameter int  N_REQ       = 4,
    parameter int  HOLD_CYCLES = 32,
    localparam int CNT_W       = $clog2(HOLD_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             ack_pulse,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack_o,
    output logic [7:0]       out,
    output logic             busy,
    output logic [CNT_W-1:0] slice_cnt
);

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = N_REQ'(1) << i;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        next_idx = (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    state_t           state, state_n;
    logic [IDX_W-1:0] cur, cur_n;
    logic [IDX_W-1:0] rr_ptr, ptr_n;
    logic [N_REQ-1:0] grant_n, ack_n;
    logic [7:0]       out_n;
    logic [CNT_W-1:0] cnt_n;

    logic             idle_valid, rot_valid;
    logic [IDX_W-1:0] idle_idx, rot_idx;
    logic [N_REQ-1:0] rot_req;
    logic [IDX_W-1:0] rot_start;
    logic             cur_req;
    logic             slice_last;

    // Rotation only considers the other sources, starting just past the owner
    assign rot_req    = req & ~onehot(cur);
    assign rot_start  = next_idx(cur);
    assign cur_req    = |(req & onehot(cur));
    assign slice_last = (slice_cnt == CNT_W'(HOLD_CYCLES - 1));

    rr_pick #(.N_REQ(N_REQ)) u_pick_idle (
        .req   (req),
        .start (rr_ptr),
        .valid (idle_valid),
        .index (idle_idx)
    );

    rr_pick #(.N_REQ(N_REQ)) u_pick_rot (
        .req   (rot_req),
        .start (rot_start),
        .valid (rot_valid),
        .index (rot_idx)
    );

    // Next-state and next-output decode; ack outranks withdrawal outranks slice expiry
    always_comb begin
        state_n = state;
        cur_n   = cur;
        ptr_n   = rr_ptr;
        grant_n = grant;
        ack_n   = '0;
        out_n   = out;
        cnt_n   = slice_cnt;
        case (state)
            IDLE: begin
                grant_n = '0;
                out_n   = '0;
                cnt_n   = '0;
                if (idle_valid) begin
                    state_n = ACTIVE;
                    cur_n   = idle_idx;
                    grant_n = onehot(idle_idx);
                    out_n   = make_out(idle_idx);
                end
            end
            ACTIVE: begin
                if (ack_pulse) begin
                    state_n = ACKED;
                    grant_n = '0;
                    out_n   = '0;
                    cnt_n   = '0;
                    ack_n   = onehot(cur);
                    ptr_n   = next_idx(cur);
                end else if (!cur_req) begin
                    state_n = IDLE;
                    grant_n = '0;
                    out_n   = '0;
                    cnt_n   = '0;
                    ptr_n   = next_idx(cur);
                end else if (slice_last) begin
                    cnt_n = '0;
                    if (rot_valid) begin
                        cur_n   = rot_idx;
                        grant_n = onehot(rot_idx);
                        out_n   = make_out(rot_idx);
                        ptr_n   = next_idx(rot_idx);
                    end
                end else begin
                    cnt_n = slice_cnt + 1'b1;
                end
            end
            ACKED: begin
                state_n = IDLE;
                grant_n = '0;
                out_n   = '0;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                out_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // Register state and every output so the pins never see decode glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            ack_o     <= '0;
            out       <= '0;
            busy      <= 1'b0;
            slice_cnt <= '0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            rr_ptr    <= ptr_n;
            grant     <= grant_n;
            ack_o     <= ack_n;
            out       <= out_n;
            busy      <= (state_n != IDLE);
            slice_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_alarm_arbiter.sv
// tb/tb_alarm_arbiter.sv - scoreboard bench for alarm_arbiter against a behavioural model
module tb_alarm_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 32;
    localparam int CW   = $clog2(HOLD);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic          ack_pulse = 1'b0;
    logic [N-1:0]  grant;
    logic [N-1:0]  ack_o;
    logic [7:0]    out;
    logic          busy;
    logic [CW-1:0] slice_cnt;

    always #5 clk = ~clk;

    alarm_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack_pulse (ack_pulse),
        .grant     (grant),
        .ack_o     (ack_o),
        .out       (out),
        .busy      (busy),
        .slice_cnt (slice_cnt)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [N-1:0]  ack;
        logic [7:0]    out;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Model: who owns the bus, who is being acknowledged, how long the slice has run
    int m_owner, m_acked, m_ticks, m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_find(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++) begin
            if (r[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_acked = -1;
        m_ticks = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_acked >= 0) begin
            m_acked = -1;
        end else if (m_owner < 0) begin
            w = rr_find(req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_ticks = 0;
            end
        end else if (ack_pulse) begin
            m_acked = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_ticks = 0;
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_ticks = 0;
        end else if (m_ticks == HOLD - 1) begin
            w = rr_find(req & ~(4'(1) << m_owner), (m_owner + 1) % N);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
            end
            m_ticks = 0;
        end else begin
            m_ticks++;
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.grant = (m_owner >= 0) ? (4'(1) << m_owner) : '0;
        x.ack   = (m_acked >= 0) ? (4'(1) << m_acked) : '0;
        x.out   = (m_owner >= 0) ? 8'(m_owner * 2 + 1) : 8'h00;
        x.busy  = (m_owner >= 0) || (m_acked >= 0);
        x.cnt   = CW'(m_ticks);
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        q.push_back(model_out());
        #1;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_out", 32'(out), 32'h0);
        check("async_rst_ack", 32'(ack_o), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_cnt", 32'(slice_cnt), 32'h0);
        q.delete();
        model_reset();
        step();
        reset = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents its registered outputs; compare with the oldest prediction
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("ack_o", 32'(ack_o), 32'(e.ack));
            check("out", 32'(out), 32'(e.out));
            check("busy", 32'(busy), 32'(e.busy));
            check("slice_cnt", 32'(slice_cnt), 32'(e.cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) step();
        reset = 1'b0;

        // First grant from reset
        req = 4'b0100;
        step();
        @(negedge clk);
        check("first_grant", 32'(grant), 32'h4);
        check("first_out", 32'(out), 32'h05);
        check("first_busy", 32'(busy), 32'h1);

        // Ack clears ch2
        ack_pulse = 1'b1;
        step();
        ack_pulse = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        check("ack_pulse_o", 32'(ack_o), 32'h4);
        check("ack_out_zero", 32'(out), 32'h0);
        step();
        @(negedge clk);
        check("ack_then_idle", 32'(busy), 32'h0);

        // Two sources share by time slice
        req = 4'b0011;
        step();
        @(negedge clk);
        check("slice_start", 32'(grant), 32'h1);
        repeat (31) step();
        @(negedge clk);
        check("slice_end_grant", 32'(grant), 32'h1);
        check("slice_end_cnt", 32'(slice_cnt), 32'(HOLD - 1));
        step();
        @(negedge clk);
        check("rotate_grant", 32'(grant), 32'h2);
        check("rotate_out", 32'(out), 32'h03);
        repeat (32) step();
        @(negedge clk);
        check("rotate_back", 32'(grant), 32'h1);
        req = 4'b0000;
        repeat (2) step();

        // Lone requester keeps the bus across slice wraps
        req = 4'b1000;
        repeat (70) step();
        @(negedge clk);
        check("lone_grant", 32'(grant), 32'h8);
        check("lone_cnt", 32'(slice_cnt), 32'(69 % HOLD));
        req = 4'b0000;
        repeat (2) step();

        // Ack coincides with slice expiry: ack wins
        req = 4'b0011;
        repeat (32) step();
        ack_pulse = 1'b1;
        step();
        ack_pulse = 1'b0;
        @(negedge clk);
        check("ack_vs_expiry_ack", 32'(ack_o), 32'h1);
        check("ack_vs_expiry_grant", 32'(grant), 32'h0);
        step();
        @(negedge clk);
        check("ack_vs_expiry_idle", 32'(busy), 32'h0);
        step();
        @(negedge clk);
        check("ack_vs_expiry_next", 32'(grant), 32'h2);
        req = 4'b0000;
        repeat (2) step();

        // Asynchronous reset in the middle of a slice
        req = 4'b1001;
        repeat (6) step();
        async_reset_pulse();
        req = 4'b1001;
        step();
        @(negedge clk);
        check("post_reset_grant", 32'(grant), 32'h1);
        check("post_reset_out", 32'(out), 32'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            ack_pulse = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
            step();
        end
        ack_pulse = 1'b0;
        req = '0;
        repeat (3) step();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
